// File: rtl/module_rca_accumulator_pkg.sv
// rtl/module_rca_accumulator_pkg.sv - shared types and defaults for the RCA accumulator
package pkg_rca_accumulator;

    localparam int ACCWIDE_DEFAULT = 64;
    localparam int NOPS_DEFAULT    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/module_rca_accumulator_rca.sv
// rtl/module_rca_accumulator_rca.sv - ripple-carry adder built from single-bit full adders

module module_bit_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // One bit of sum and carry-out.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

module module_ripple_carry_adder #(
    parameter int RCAWIDE = 64
) (
    input  logic [RCAWIDE-1:0] a_i,
    input  logic [RCAWIDE-1:0] b_i,
    input  logic               carry_i,
    output logic [RCAWIDE-1:0] sum_o,
    output logic               carry_o
);

    logic [RCAWIDE:0] carry_chain;

    assign carry_chain[0] = carry_i;
    assign carry_o        = carry_chain[RCAWIDE];

    // Carry ripples from bit 0 upward through one full adder per bit.
    for (genvar i = 0; i < RCAWIDE; i++) begin : g_bit
        module_bit_full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry_chain[i]),
            .s_o (sum_o[i]),
            .c_o (carry_chain[i+1])
        );
    end

endmodule

// File: rtl/module_rca_accumulator.sv
// rtl/module_rca_accumulator.sv - multi-operand accumulator over a ripple-carry adder
module module_rca_accumulator
    import pkg_rca_accumulator::*;
#(
    parameter int ACCWIDE = ACCWIDE_DEFAULT,
    parameter int NOPS    = NOPS_DEFAULT,
    parameter int CNTWIDE = $clog2(NOPS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic [ACCWIDE-1:0] op_i,
    input  logic               op_valid_i,
    output logic               op_ready_o,
    output logic [ACCWIDE-1:0] sum_o,
    output logic               overflow_o,
    output logic [CNTWIDE-1:0] count_o,
    output logic               sum_valid_o,
    input  logic               sum_ready_i
);

    if (ACCWIDE < 2) begin : g_bad_width
        $error("ACCWIDE must be at least 2");
    end
    if (NOPS < 1) begin : g_bad_nops
        $error("NOPS must be at least 1");
    end

    localparam logic [CNTWIDE-1:0] COUNT_LAST = CNTWIDE'(NOPS);

    acc_state_t         state_q, state_d;
    logic [ACCWIDE-1:0] acc_q, acc_d;
    logic [CNTWIDE-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACCWIDE-1:0] rca_sum;
    logic               rca_carry;
    logic [CNTWIDE-1:0] count_inc;
    logic               accept;

    // Ready is a pure state decode so it never depends on the downstream ready.
    assign op_ready_o  = (state_q != DONE);
    assign accept      = op_valid_i & op_ready_o;
    assign count_inc   = count_q + CNTWIDE'(1);

    assign sum_o       = acc_q;
    assign overflow_o  = ovf_q;
    assign count_o     = count_q;
    assign sum_valid_o = (state_q == DONE);

    module_ripple_carry_adder #(
        .RCAWIDE (ACCWIDE)
    ) u_rca (
        .a_i     (acc_q),
        .b_i     (op_i),
        .carry_i (1'b0),
        .sum_o   (rca_sum),
        .carry_o (rca_carry)
    );

    // Next-state: clear wins, then operand accept, then result handshake.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = rca_sum;
                        ovf_d   = ovf_q | rca_carry;
                        count_d = count_inc;
                        state_d = (count_inc == COUNT_LAST) ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (sum_ready_i) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State, accumulator, counter and sticky overflow registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_module_rca_accumulator.sv
// tb/tb_module_rca_accumulator.sv - scoreboard bench for the RCA accumulator
module tb_module_rca_accumulator;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
        logic [2:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] op = '0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [7:0] sum;
    logic       overflow;
    logic [2:0] count;
    logic       sum_valid;
    logic       sum_ready = 1'b0;

    logic       clear1 = 1'b0;
    logic [7:0] op1 = '0;
    logic       op1_valid = 1'b0;
    logic       op1_ready;
    logic [7:0] sum1;
    logic       overflow1;
    logic [0:0] count1;
    logic       sum1_valid;
    logic       sum1_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    module_rca_accumulator #(.ACCWIDE(8), .NOPS(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .op_i        (op),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .sum_o       (sum),
        .overflow_o  (overflow),
        .count_o     (count),
        .sum_valid_o (sum_valid),
        .sum_ready_i (sum_ready)
    );

    module_rca_accumulator #(.ACCWIDE(8), .NOPS(1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear1),
        .op_i        (op1),
        .op_valid_i  (op1_valid),
        .op_ready_o  (op1_ready),
        .sum_o       (sum1),
        .overflow_o  (overflow1),
        .count_o     (count1),
        .sum_valid_o (sum1_valid),
        .sum_ready_i (sum1_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] s, input logic o, input logic [2:0] c);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cnt = c;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] x);
        int n;
        n = 0;
        op = x;
        op_valid = 1'b1;
        while (!op_ready && n < 50) begin
            tick();
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d required=%0d", op_ready, 1);
        end
        tick();
        op_valid = 1'b0;
    endtask

    task automatic handshake();
        int n;
        n = 0;
        while (!sum_valid && n < 50) begin
            tick();
            n++;
        end
        if (!sum_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout actual=%0d required=%0d", sum_valid, 1);
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    // Monitor for the NOPS=4 instance: compare every completed result handshake.
    always @(negedge clk) begin
        if (!rst && sum_valid && sum_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0d required=none", sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_sum", 64'(sum), 64'(e.sum));
                chk("sb_overflow", 64'(overflow), 64'(e.ovf));
                chk("sb_count", 64'(count), 64'(e.cnt));
            end
        end
    end

    // Monitor for the NOPS=1 instance.
    always @(negedge clk) begin
        if (!rst && sum1_valid && sum1_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result1 actual=%0d required=none", sum1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sb1_sum", 64'(sum1), 64'(e.sum));
                chk("sb1_overflow", 64'(overflow1), 64'(e.ovf));
                chk("sb1_count", 64'(count1), 64'(e.cnt));
            end
        end
    end

    initial begin
        logic [7:0] gap_ops [4];
        logic [7:0] one_ops [4];
        gap_ops = '{8'd10, 8'd20, 8'd30, 8'd40};
        one_ops = '{8'd17, 8'd200, 8'd255, 8'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_valid", 64'(sum_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_op_ready", 64'(op_ready), 64'd1);

        // Basic sum
        push(8'd24, 1'b0, 3'd4);
        send(8'd3); send(8'd5); send(8'd7); send(8'd9);
        chk("basic_valid", 64'(sum_valid), 64'd1);
        chk("basic_ready_low", 64'(op_ready), 64'd0);
        chk("basic_sum", 64'(sum), 64'd24);
        handshake();
        chk("basic_after_valid", 64'(sum_valid), 64'd0);
        chk("basic_after_ready", 64'(op_ready), 64'd1);

        // Overflow, then flag cleared on the next accumulation
        push(8'd46, 1'b1, 3'd4);
        send(8'd200); send(8'd100); send(8'd1); send(8'd1);
        handshake();
        push(8'd4, 1'b0, 3'd4);
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        handshake();

        // Carry-out on the final operand only
        push(8'd4, 1'b1, 3'd4);
        send(8'd10); send(8'd0); send(8'd0); send(8'd250);
        handshake();

        // Backpressure in DONE with an operand waiting
        push(8'd15, 1'b0, 3'd4);
        send(8'd1); send(8'd2); send(8'd4); send(8'd8);
        op = 8'd99;
        op_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_sum", 64'(sum), 64'd15);
            chk("bp_count", 64'(count), 64'd4);
            chk("bp_ready", 64'(op_ready), 64'd0);
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
        op_valid = 1'b0;
        chk("bp_release_ready", 64'(op_ready), 64'd1);
        chk("bp_release_count", 64'(count), 64'd0);
        chk("bp_release_valid", 64'(sum_valid), 64'd0);

        // Gapped input
        push(8'd100, 1'b0, 3'd4);
        for (int i = 0; i < 4; i++) begin
            send(gap_ops[i]);
            tick();
            chk("gap_count", 64'(count), 64'(i + 1));
        end
        handshake();

        // Abort with an operand in flight
        send(8'd5); send(8'd6);
        chk("abort_pre_count", 64'(count), 64'd2);
        clear = 1'b1;
        op = 8'd55;
        op_valid = 1'b1;
        tick();
        clear = 1'b0;
        op_valid = 1'b0;
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_ready", 64'(op_ready), 64'd1);
        push(8'd10, 1'b0, 3'd4);
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        handshake();

        // Asynchronous reset between clock edges
        send(8'd7); send(8'd8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_sum", 64'(sum), 64'd0);
        chk("async_valid", 64'(sum_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("async_ready", 64'(op_ready), 64'd1);

        // NOPS=1 corner
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.sum = one_ops[i];
            e.ovf = 1'b0;
            e.cnt = 3'd1;
            q1.push_back(e);
            op1 = one_ops[i];
            op1_valid = 1'b1;
            tick();
            op1_valid = 1'b0;
            chk("n1_valid", 64'(sum1_valid), 64'd1);
            chk("n1_sum", 64'(sum1), 64'(one_ops[i]));
            tick();
        end

        tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("queue1_drained", 64'(q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_rca_accumulator.md
Name: module_rca_accumulator

Overview:
- Sequential multi-operand accumulator that sits directly upstream of the result consumer and drives one `module_ripple_carry_adder` instance as its combinational datapath.
- Accepts a stream of NOPS unsigned operands over a valid/ready handshake and sums them into a registered accumulator.
- Presents the final sum plus a sticky overflow flag over a second valid/ready handshake.
- Lets a ripple-carry adder build multi-operand sums one operand per clock.

Parameters:
- ACCWIDE, 64, bit width of operands, accumulator and sum; passed to the RCA instance as RCAWIDE; must be ≥ 2.
- NOPS, 4, operands per accumulation; must be ≥ 1.
- CNTWIDE, $clog2(NOPS+1), width of the operand counter (derived, not overridden).

Ports:
- clk_i  input  1  single system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- clear_i  input  1  synchronous abort; discards the accumulation in progress.
- op_i  input  ACCWIDE  operand.
- op_valid_i  input  1  operand valid.
- op_ready_o  output  1  accumulator can accept an operand.
- sum_o  output  ACCWIDE  accumulated sum; stable while sum_valid_o=1.
- overflow_o  output  1  sticky: at least one RCA carry-out occurred during this accumulation.
- count_o  output  CNTWIDE  operands accepted in the current accumulation.
- sum_valid_o  output  1  result available.
- sum_ready_i  input  1  downstream accepts the result.

Behaviour:
- Reset: while rst_i is asserted, all registers are cleared asynchronously.
  - State=IDLE, acc=0, overflow_o=0, count_o=0, sum_valid_o=0.
  - op_ready_o=1 after reset release.
- Datapath: the RCA instance sums the current acc (a_i) and op_i (b_i) with carry_i=0.
  - On acceptance, acc ← sum_o of the RCA.
  - overflow ← overflow | carry_o of the RCA.
  - Arithmetic is unsigned modulo 2^ACCWIDE.
- Acceptance: an operand is accepted when op_valid_i & op_ready_o on a rising edge.
- op_ready_o=1 in IDLE and ACCUM and 0 in DONE. It is a registered-state decode with no combinational path from sum_ready_i.
- FSM (state enum from the package):
  - IDLE: acc=0, count=0.
    - Accept with NOPS=1 → DONE.
    - Accept with NOPS>1 → ACCUM, count=1.
    - No accept → stay in IDLE.
  - ACCUM: on each accept, count increments.
    - The accept that brings count to NOPS → DONE.
    - No accept → hold all registers.
  - DONE: sum_valid_o=1; sum_o=acc; overflow_o and count_o=NOPS held.
    - sum_valid_o & sum_ready_i → IDLE; on that same edge acc, count and overflow clear to 0.
    - Otherwise hold. sum_valid_o never drops without a handshake, except on clear_i or reset.
- Latency: sum_valid_o rises on the clock edge that accepts the NOPS-th operand, so it is visible the cycle after that operand is presented with ready.
- Throughput:
  - NOPS operand cycles plus one DONE cycle minimum per result.
  - In DONE with sum_ready_i=1, the FSM returns to IDLE. The next operand is accepted no earlier than the following cycle.
- clear_i has priority over all handshakes.
  - From any state, the next edge gives IDLE, acc=0, count=0, overflow=0, sum_valid_o=0.
  - An operand presented in the same cycle as clear_i is dropped, not accumulated.
- sum_o is driven from acc in all states, but is meaningful only while sum_valid_o=1.
- Wrap-around: the accumulator wraps silently and overflow_o records it. A carry-out on the final operand also sets overflow_o.
- Reset mid-accumulation aborts immediately: asynchronous clear, partial result lost, no sum_valid_o pulse.

Decomposition:
- Package `pkg_rca_accumulator` holds:
  - Typedef `acc_state_t` enum {IDLE, ACCUM, DONE} (2 bits).
  - Localparam defaults for ACCWIDE and NOPS.
- One sub-module: `module_ripple_carry_adder` (RCAWIDE=ACCWIDE), instantiated once. It in turn uses `module_bit_full_adder`.
- The FSM, counter and sticky flag stay in this module.

Test Plan:
1. Basic sum: ACCWIDE=8, NOPS=4, operands 3, 5, 7, 9 back-to-back → sum_valid_o rises the cycle after 9 is accepted; sum_o=24, overflow_o=0, count_o=4; op_ready_o=0 until the handshake.
2. Overflow: ACCWIDE=8, operands 200, 100, 1, 1 → sum_o=46 (302 mod 256), overflow_o=1. Next accumulation 1, 1, 1, 1 → sum_o=4, overflow_o=0 (flag cleared on handshake).
3. Backpressure: hold sum_ready_i=0 for 10 cycles in DONE while op_valid_i=1 → sum_o, overflow_o and count_o stable, no operand accepted. sum_ready_i=1 for one cycle → IDLE next cycle, op_ready_o=1.
4. Gapped input: operands 10, 20, 30, 40 with op_valid_i toggling 1/0 → same result 100; count_o increments only on accept cycles.
5. Abort: after two operands (count_o=2), pulse clear_i with op_valid_i=1, op_i=55 → next cycle IDLE, count_o=0. Then 1, 2, 3, 4 → sum_o=10 (55 not included).
6. Async reset: assert rst_i mid-ACCUM between clock edges → outputs go to reset values immediately, without waiting for clk_i. NOPS=1 corner: each accepted operand x yields sum_o=x on the next cycle.
